// File: rtl/rv_writeback_pkg.sv
// Shared definitions for the integer writeback stage: widths, load funct3
// encodings and the load-tracking FSM state type.
package rv_writeback_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_LD_WAIT = 1'b1
    } wb_state_e;

endpackage

// File: rtl/rv_load_align.sv
// Combinational load formatter: selects the byte or halfword addressed by
// addr_lo from an aligned memory word and sign/zero-extends it.
module rv_load_align
    import rv_writeback_pkg::*;
#(
    parameter int unsigned W = XLEN
) (
    input  logic [2:0]   funct3_i,
    input  logic [1:0]   addr_lo_i,
    input  logic [W-1:0] rdata_i,
    output logic [W-1:0] data_o
);

    logic [W-1:0] byte_sh;
    logic [W-1:0] half_sh;

    // Halfwords use addr_lo[1] only; misaligned accesses trap upstream.
    always_comb begin
        byte_sh = rdata_i >> {addr_lo_i, 3'b000};
        half_sh = rdata_i >> {addr_lo_i[1], 4'b0000};
        data_o  = rdata_i;
        case (funct3_i)
            F3_LB:   data_o = {{(W-8){byte_sh[7]}}, byte_sh[7:0]};
            F3_LBU:  data_o = {{(W-8){1'b0}}, byte_sh[7:0]};
            F3_LH:   data_o = {{(W-16){half_sh[15]}}, half_sh[15:0]};
            F3_LHU:  data_o = {{(W-16){1'b0}}, half_sh[15:0]};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/rv_writeback.sv
// Register-file write port producer: arbitrates load responses over ALU
// results (with a one-entry ALU skid) and tracks the single outstanding load.
module rv_writeback
    import rv_writeback_pkg::*;
#(
    parameter int unsigned XLEN   = rv_writeback_pkg::XLEN,
    parameter int unsigned REG_AW = rv_writeback_pkg::REG_AW
) (
    input  logic              i_clock,
    input  logic              i_rst,
    input  logic              i_alu_valid,
    output logic              o_alu_ready,
    input  logic [REG_AW-1:0] i_alu_rd,
    input  logic [XLEN-1:0]   i_alu_dat,
    input  logic              i_ld_req,
    output logic              o_ld_req_ready,
    input  logic [REG_AW-1:0] i_ld_rd,
    input  logic [2:0]        i_ld_funct3,
    input  logic [1:0]        i_ld_addr_lo,
    input  logic              i_ld_rvalid,
    input  logic [XLEN-1:0]   i_ld_rdata,
    output logic              o_ld_pending,
    output logic [REG_AW-1:0] o_ld_pending_rd,
    output logic              o_write_cs,
    output logic [REG_AW-1:0] o_rd,
    output logic [XLEN-1:0]   o_regdat
);

    wb_state_e         state_q, state_d;
    logic [REG_AW-1:0] ld_rd_q, ld_rd_d;
    logic [2:0]        ld_f3_q, ld_f3_d;
    logic [1:0]        ld_lo_q, ld_lo_d;

    logic              skid_full_q, skid_full_d;
    logic [REG_AW-1:0] skid_rd_q, skid_rd_d;
    logic [XLEN-1:0]   skid_dat_q, skid_dat_d;

    logic              wcs_q, wcs_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [XLEN-1:0]   dat_q, dat_d;

    logic              ld_resp;
    logic              alu_acc;
    logic              ld_acc;
    logic [XLEN-1:0]   ld_fmt;

    rv_load_align #(
        .W (XLEN)
    ) u_align (
        .funct3_i  (ld_f3_q),
        .addr_lo_i (ld_lo_q),
        .rdata_i   (i_ld_rdata),
        .data_o    (ld_fmt)
    );

    assign ld_resp        = (state_q == ST_LD_WAIT) && i_ld_rvalid;
    assign o_alu_ready    = !skid_full_q;
    assign alu_acc        = i_alu_valid && o_alu_ready;
    assign o_ld_req_ready = (state_q == ST_IDLE) || ld_resp;
    assign ld_acc         = i_ld_req && o_ld_req_ready;

    // Load-tracking FSM: a response and a new request may share a cycle.
    always_comb begin
        state_d = state_q;
        ld_rd_d = ld_rd_q;
        ld_f3_d = ld_f3_q;
        ld_lo_d = ld_lo_q;
        case (state_q)
            ST_IDLE: begin
                if (ld_acc) state_d = ST_LD_WAIT;
            end
            ST_LD_WAIT: begin
                if (i_ld_rvalid && !ld_acc) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (ld_acc) begin
            ld_rd_d = i_ld_rd;
            ld_f3_d = i_ld_funct3;
            ld_lo_d = i_ld_addr_lo;
        end
    end

    // Write arbitration: load response, then skid entry, then live ALU.
    always_comb begin
        skid_full_d = skid_full_q;
        skid_rd_d   = skid_rd_q;
        skid_dat_d  = skid_dat_q;
        wcs_d       = 1'b0;
        rd_d        = rd_q;
        dat_d       = dat_q;
        if (ld_resp) begin
            wcs_d = (ld_rd_q != '0);
            if (ld_rd_q != '0) begin
                rd_d  = ld_rd_q;
                dat_d = ld_fmt;
            end
            if (alu_acc) begin
                skid_full_d = 1'b1;
                skid_rd_d   = i_alu_rd;
                skid_dat_d  = i_alu_dat;
            end
        end else if (skid_full_q) begin
            skid_full_d = 1'b0;
            wcs_d       = (skid_rd_q != '0);
            if (skid_rd_q != '0) begin
                rd_d  = skid_rd_q;
                dat_d = skid_dat_q;
            end
        end else if (alu_acc) begin
            wcs_d = (i_alu_rd != '0);
            if (i_alu_rd != '0) begin
                rd_d  = i_alu_rd;
                dat_d = i_alu_dat;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            ld_rd_q     <= '0;
            ld_f3_q     <= '0;
            ld_lo_q     <= '0;
            skid_full_q <= 1'b0;
            skid_rd_q   <= '0;
            skid_dat_q  <= '0;
            wcs_q       <= 1'b0;
            rd_q        <= '0;
            dat_q       <= '0;
        end else begin
            state_q     <= state_d;
            ld_rd_q     <= ld_rd_d;
            ld_f3_q     <= ld_f3_d;
            ld_lo_q     <= ld_lo_d;
            skid_full_q <= skid_full_d;
            skid_rd_q   <= skid_rd_d;
            skid_dat_q  <= skid_dat_d;
            wcs_q       <= wcs_d;
            rd_q        <= rd_d;
            dat_q       <= dat_d;
        end
    end

    assign o_write_cs      = wcs_q;
    assign o_rd            = rd_q;
    assign o_regdat        = dat_q;
    assign o_ld_pending    = (state_q == ST_LD_WAIT);
    assign o_ld_pending_rd = o_ld_pending ? ld_rd_q : '0;

endmodule

// File: tb/tb_rv_writeback.sv
// Directed self-checking bench for rv_writeback.
module tb_rv_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_dat;
    logic        ld_req;
    logic        ld_req_ready;
    logic [4:0]  ld_rd;
    logic [2:0]  ld_f3;
    logic [1:0]  ld_lo;
    logic        ld_rvalid;
    logic [31:0] ld_rdata;
    logic        ld_pending;
    logic [4:0]  ld_pending_rd;
    logic        write_cs;
    logic [4:0]  wr_rd;
    logic [31:0] regdat;

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

    rv_writeback #(
        .XLEN   (32),
        .REG_AW (5)
    ) dut (
        .i_clock         (clk),
        .i_rst           (rst),
        .i_alu_valid     (alu_valid),
        .o_alu_ready     (alu_ready),
        .i_alu_rd        (alu_rd),
        .i_alu_dat       (alu_dat),
        .i_ld_req        (ld_req),
        .o_ld_req_ready  (ld_req_ready),
        .i_ld_rd         (ld_rd),
        .i_ld_funct3     (ld_f3),
        .i_ld_addr_lo    (ld_lo),
        .i_ld_rvalid     (ld_rvalid),
        .i_ld_rdata      (ld_rdata),
        .o_ld_pending    (ld_pending),
        .o_ld_pending_rd (ld_pending_rd),
        .o_write_cs      (write_cs),
        .o_rd            (wr_rd),
        .o_regdat        (regdat)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_wr(input string tag, input logic [4:0] rd, input logic [31:0] dat);
        check({tag, ".cs"}, {31'd0, write_cs}, 32'd1);
        check({tag, ".rd"}, {27'd0, wr_rd}, {27'd0, rd});
        check({tag, ".dat"}, regdat, dat);
    endtask

    // Issue a load, wait one idle cycle, then deliver the response.
    task automatic do_load(input string tag, input logic [4:0] rd, input logic [2:0] f3,
                           input logic [1:0] lo, input logic [31:0] rdata, input logic [31:0] exp);
        ld_req = 1'b1; ld_rd = rd; ld_f3 = f3; ld_lo = lo;
        #1;
        check({tag, ".req_ready"}, {31'd0, ld_req_ready}, 32'd1);
        step();
        ld_req = 1'b0; ld_rd = 5'd0;
        #1;
        check({tag, ".pending"}, {31'd0, ld_pending}, 32'd1);
        check({tag, ".pending_rd"}, {27'd0, ld_pending_rd}, {27'd0, rd});
        check({tag, ".busy_ready"}, {31'd0, ld_req_ready}, 32'd0);
        step();
        check({tag, ".wait_cs"}, {31'd0, write_cs}, 32'd0);
        ld_rvalid = 1'b1; ld_rdata = rdata;
        step();
        ld_rvalid = 1'b0;
        check_wr(tag, rd, exp);
        check({tag, ".done"}, {31'd0, ld_pending}, 32'd0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; alu_valid = 1'b1; alu_rd = 5'd9; alu_dat = 32'h0000_00AA;
        ld_req = 1'b0; ld_rd = '0; ld_f3 = '0; ld_lo = '0;
        ld_rvalid = 1'b0; ld_rdata = '0;

        for (int i = 0; i < 3; i++) begin
            step();
            check("rst.cs", {31'd0, write_cs}, 32'd0);
            check("rst.pending", {31'd0, ld_pending}, 32'd0);
            check("rst.rd", {27'd0, wr_rd}, 32'd0);
            check("rst.dat", regdat, 32'd0);
        end
        rst = 1'b0;
        step();
        check_wr("rst_release", 5'd9, 32'h0000_00AA);
        alu_valid = 1'b0;
        step();
        check("idle.cs", {31'd0, write_cs}, 32'd0);

        alu_valid = 1'b1; alu_rd = 5'd5; alu_dat = 32'h0000_1234;
        step();
        alu_valid = 1'b0;
        check_wr("alu", 5'd5, 32'h0000_1234);

        alu_valid = 1'b1; alu_rd = 5'd0; alu_dat = 32'h0000_5555;
        step();
        alu_valid = 1'b0;
        check("alu_x0.cs", {31'd0, write_cs}, 32'd0);
        check("alu_x0.rd_hold", {27'd0, wr_rd}, 32'd5);
        check("alu_x0.dat_hold", regdat, 32'h0000_1234);

        do_load("lb1",  5'd4, 3'b000, 2'd1, 32'h80FF_7F01, 32'h0000_007F);
        do_load("lb3",  5'd6, 3'b000, 2'd3, 32'h80FF_7F01, 32'hFFFF_FF80);
        do_load("lhu2", 5'd8, 3'b101, 2'd2, 32'h80FF_7F01, 32'h0000_80FF);
        do_load("lw",   5'd9, 3'b010, 2'd0, 32'h80FF_7F01, 32'h80FF_7F01);
        do_load("lh3",  5'd2, 3'b001, 2'd3, 32'h80FF_7F01, 32'hFFFF_80FF);
        do_load("f3_11", 5'd1, 3'b011, 2'd2, 32'h80FF_7F01, 32'h80FF_7F01);

        // Load response and ALU result collide.
        ld_req = 1'b1; ld_rd = 5'd3; ld_f3 = 3'b010; ld_lo = 2'd0;
        step();
        ld_req = 1'b0;
        ld_rvalid = 1'b1; ld_rdata = 32'h1111_2222;
        alu_valid = 1'b1; alu_rd = 5'd7; alu_dat = 32'h0000_0077;
        #1;
        check("coll.alu_ready0", {31'd0, alu_ready}, 32'd1);
        step();
        ld_rvalid = 1'b0; alu_valid = 1'b0;
        check_wr("coll.c1", 5'd3, 32'h1111_2222);
        check("coll.alu_ready1", {31'd0, alu_ready}, 32'd0);
        step();
        check_wr("coll.c2", 5'd7, 32'h0000_0077);
        check("coll.alu_ready2", {31'd0, alu_ready}, 32'd1);
        step();
        check("coll.after", {31'd0, write_cs}, 32'd0);

        // Back-to-back loads.
        ld_req = 1'b1; ld_rd = 5'd10; ld_f3 = 3'b100; ld_lo = 2'd0;
        step();
        ld_rvalid = 1'b1; ld_rdata = 32'h0000_00C3;
        ld_req = 1'b1; ld_rd = 5'd11; ld_f3 = 3'b001; ld_lo = 2'd2;
        #1;
        check("b2b.req_ready", {31'd0, ld_req_ready}, 32'd1);
        step();
        ld_req = 1'b0;
        check_wr("b2b.first", 5'd10, 32'h0000_00C3);
        check("b2b.pending", {31'd0, ld_pending}, 32'd1);
        check("b2b.pending_rd", {27'd0, ld_pending_rd}, 32'd11);
        ld_rdata = 32'h8001_0000;
        step();
        ld_rvalid = 1'b0;
        check_wr("b2b.second", 5'd11, 32'hFFFF_8001);
        check("b2b.done", {31'd0, ld_pending}, 32'd0);

        // Stray response with nothing pending.
        ld_rvalid = 1'b1; ld_rdata = 32'hDEAD_BEEF;
        step();
        ld_rvalid = 1'b0;
        check("stray.cs", {31'd0, write_cs}, 32'd0);
        check("stray.dat_hold", regdat, 32'hFFFF_8001);

        // Reset while a load is outstanding.
        ld_req = 1'b1; ld_rd = 5'd12; ld_f3 = 3'b010; ld_lo = 2'd0;
        step();
        ld_req = 1'b0;
        check("rstld.pending", {31'd0, ld_pending}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rstld.cleared", {31'd0, ld_pending}, 32'd0);
        ld_rvalid = 1'b1; ld_rdata = 32'h1234_5678;
        step();
        ld_rvalid = 1'b0;
        check("rstld.cs", {31'd0, write_cs}, 32'd0);
        check("rstld.pending2", {31'd0, ld_pending}, 32'd0);
        check("rstld.dat", regdat, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
